// File: rtl/ila_trigger_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ila_trigger_capture_ctrl_if
// Purpose  : Control, trigger-pulse and sample-buffer signals of the capture
//            sequencer, grouped with master (driver) / slave (sequencer) views.
// Revision : 1.0 - initial release
// ============================================================================
interface ila_trigger_capture_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int OCC_W  = 8
);
  logic              i_start;
  logic              i_stop;
  logic [1:0]        i_mode;
  logic              i_pedge;
  logic              i_nedge;
  logic [OCC_W-1:0]  i_occurrence;
  logic [ADDR_W-1:0] i_pre_samples;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [ADDR_W-1:0] o_trig_addr;
  logic              o_triggered;
  logic              o_done;
  logic              o_busy;

  modport master (
    output i_start, i_stop, i_mode, i_pedge, i_nedge, i_occurrence, i_pre_samples,
    input  o_wr_en, o_wr_addr, o_trig_addr, o_triggered, o_done, o_busy
  );

  modport slave (
    input  i_start, i_stop, i_mode, i_pedge, i_nedge, i_occurrence, i_pre_samples,
    output o_wr_en, o_wr_addr, o_trig_addr, o_triggered, o_done, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/ila_trigger_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ila_trigger_capture_ctrl
// Purpose  : Pre-trigger / Nth-occurrence capture sequencer driving the
//            circular sample-buffer write port.
// Revision : 1.0 - initial release
// ============================================================================
module ila_trigger_capture_ctrl #(
  parameter int ADDR_W = 12,
  parameter int OCC_W  = 8
) (
  input  wire logic                   i_clk,
  input  wire logic                   i_reset,
  ila_trigger_capture_ctrl_if.slave   ctrl_if
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE     = 3'd1,
    S_ARMED   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   c_depth    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [OCC_W-1:0]  c_occ_one  = {{(OCC_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              triggered_q, triggered_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              first_q, first_d;
  logic [1:0]        mode_q, mode_d;
  logic [OCC_W-1:0]  occ_cfg_q, occ_cfg_d;
  logic [ADDR_W-1:0] pre_q, pre_d;

  logic [ADDR_W:0]   w_cnt_inc;
  logic [ADDR_W:0]   w_post_target;
  logic [OCC_W-1:0]  w_occ_inc;
  logic [OCC_W-1:0]  w_occ_target;
  logic              w_event;

  assign w_cnt_inc     = cnt_q + c_cnt_one;
  assign w_post_target = c_depth - {1'b0, pre_q};
  assign w_occ_inc     = (&occ_q) ? occ_q : (occ_q + c_occ_one);
  assign w_occ_target  = (occ_cfg_q == '0) ? c_occ_one : occ_cfg_q;

  always_comb begin
    w_event = 1'b0;
    case (mode_q)
      2'b00:   w_event = ctrl_if.i_pedge;
      2'b01:   w_event = ctrl_if.i_nedge;
      2'b10:   w_event = ctrl_if.i_pedge | ctrl_if.i_nedge;
      default: w_event = first_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    trig_addr_d = trig_addr_q;
    triggered_d = triggered_q;
    occ_d       = occ_q;
    first_d     = 1'b0;
    mode_d      = mode_q;
    occ_cfg_d   = occ_cfg_q;
    pre_d       = pre_q;

    // Stop outranks start and a same-cycle trigger, so it is resolved first.
    if (ctrl_if.i_stop) begin
      state_d     = S_IDLE;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (ctrl_if.i_start) begin
            mode_d      = ctrl_if.i_mode;
            occ_cfg_d   = ctrl_if.i_occurrence;
            pre_d       = ctrl_if.i_pre_samples;
            wr_addr_d   = '0;
            cnt_d       = '0;
            occ_d       = '0;
            triggered_d = 1'b0;
            if (ctrl_if.i_pre_samples == '0) begin
              state_d = S_ARMED;
              first_d = 1'b1;
            end else begin
              state_d = S_PRE;
            end
          end
        end
        S_PRE: begin
          wr_addr_d = wr_addr_q + c_addr_one;
          cnt_d     = w_cnt_inc;
          if (w_cnt_inc == {1'b0, pre_q}) begin
            state_d = S_ARMED;
            first_d = 1'b1;
          end
        end
        S_ARMED: begin
          wr_addr_d = wr_addr_q + c_addr_one;
          if (w_event) begin
            occ_d = w_occ_inc;
            if (w_occ_inc == w_occ_target) begin
              trig_addr_d = wr_addr_q;
              triggered_d = 1'b1;
              cnt_d       = c_cnt_one;
              state_d     = (w_post_target == c_cnt_one) ? S_DONE : S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          wr_addr_d = wr_addr_q + c_addr_one;
          cnt_d     = w_cnt_inc;
          if (w_cnt_inc == w_post_target) begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      occ_q       <= '0;
      first_q     <= 1'b0;
      mode_q      <= '0;
      occ_cfg_q   <= '0;
      pre_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_addr_q   <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      triggered_q <= triggered_d;
      occ_q       <= occ_d;
      first_q     <= first_d;
      mode_q      <= mode_d;
      occ_cfg_q   <= occ_cfg_d;
      pre_q       <= pre_d;
    end
  end

  assign ctrl_if.o_busy      = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign ctrl_if.o_wr_en     = ctrl_if.o_busy;
  assign ctrl_if.o_done      = (state_q == S_DONE);
  assign ctrl_if.o_wr_addr   = wr_addr_q;
  assign ctrl_if.o_trig_addr = trig_addr_q;
  assign ctrl_if.o_triggered = triggered_q;

endmodule
`default_nettype wire

// File: tb/tb_ila_trigger_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ila_trigger_capture_ctrl
// Purpose  : Directed self-checking bench for the capture sequencer (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ila_trigger_capture_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  ila_trigger_capture_ctrl_if #(.ADDR_W(4), .OCC_W(8)) bus ();

  ila_trigger_capture_ctrl #(.ADDR_W(4), .OCC_W(8)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .ctrl_if (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [1:0] mode;
    logic       pedge;
    logic [7:0] occ;
    logic [3:0] pre;
    logic       exp_wr_en;
    logic [3:0] exp_addr;
    logic       exp_trig;
    logic [3:0] exp_taddr;
    logic       exp_done;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic st, input logic pe, input logic ne);
    bus.i_start = s;
    bus.i_stop  = st;
    bus.i_pedge = pe;
    bus.i_nedge = ne;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    bus.i_pedge = 1'b0;
    bus.i_nedge = 1'b0;
  endtask

  // Config is scrambled right after the start cycle to prove it was latched.
  task automatic start_run(input logic [1:0] m, input logic [7:0] o, input logic [3:0] p);
    bus.i_mode        = m;
    bus.i_occurrence  = o;
    bus.i_pre_samples = p;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    bus.i_mode        = ~m;
    bus.i_occurrence  = ~o;
    bus.i_pre_samples = ~p;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_mode = 2'b00;
    bus.i_pedge = 1'b0; bus.i_nedge = 1'b0;
    bus.i_occurrence = 8'd0; bus.i_pre_samples = 4'd0;

    #2;
    chk("por_wr_en", bus.o_wr_en, 0);
    chk("por_addr", bus.o_wr_addr, 0);
    chk("por_busy", bus.o_busy, 0);
    chk("por_done", bus.o_done, 0);
    chk("por_trig", bus.o_triggered, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode 00, pre=4, rising edge in the 10th cycle after start.
    for (int k = 0; k < 23; k++) begin
      tbl[k].start     = (k == 0);
      tbl[k].mode      = 2'b00;
      tbl[k].occ       = 8'd1;
      tbl[k].pre       = 4'd4;
      tbl[k].pedge     = (k == 10);
      tbl[k].exp_wr_en = (k <= 20);
      tbl[k].exp_addr  = (k <= 21) ? 4'(k) : 4'd5;
      tbl[k].exp_trig  = (k >= 10);
      tbl[k].exp_taddr = (k >= 10) ? 4'd9 : 4'd0;
      tbl[k].exp_done  = (k >= 21);
    end
    for (int k = 0; k < 23; k++) begin
      bus.i_mode        = tbl[k].mode;
      bus.i_occurrence  = tbl[k].occ;
      bus.i_pre_samples = tbl[k].pre;
      step(tbl[k].start, 1'b0, tbl[k].pedge, 1'b0);
      chk($sformatf("t2_wr_en[%0d]", k), bus.o_wr_en, tbl[k].exp_wr_en);
      chk($sformatf("t2_busy[%0d]", k), bus.o_busy, tbl[k].exp_wr_en);
      chk($sformatf("t2_addr[%0d]", k), bus.o_wr_addr, tbl[k].exp_addr);
      chk($sformatf("t2_trig[%0d]", k), bus.o_triggered, tbl[k].exp_trig);
      chk($sformatf("t2_taddr[%0d]", k), bus.o_trig_addr, tbl[k].exp_taddr);
      chk($sformatf("t2_done[%0d]", k), bus.o_done, tbl[k].exp_done);
    end

    // Mode 01, occ=3, pre=0, restarted from DONE.
    start_run(2'b01, 8'd3, 4'd0);
    chk("t3_restart_done", bus.o_done, 0);
    chk("t3_restart_trig", bus.o_triggered, 0);
    chk("t3_restart_addr", bus.o_wr_addr, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk("t3_two_falls", bus.o_triggered, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("t3_trig", bus.o_triggered, 1);
    chk("t3_taddr", bus.o_trig_addr, 6);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 0);
    chk("t3_busy_before_end", bus.o_busy, 1);
    step(0, 0, 0, 0);
    chk("t3_done", bus.o_done, 1);
    chk("t3_end_addr", bus.o_wr_addr, 6);
    chk("t3_end_wr_en", bus.o_wr_en, 0);

    // Mode 10, occ=0 (acts as 1), pre=8: pulses during PRE are ignored.
    start_run(2'b10, 8'd0, 4'd8);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("t4_pre_no_trig", bus.o_triggered, 0);
    chk("t4_armed_addr", bus.o_wr_addr, 8);
    step(1, 0, 0, 0);
    chk("t4_start_ignored", bus.o_wr_addr, 9);
    step(0, 0, 0, 1);
    chk("t4_trig", bus.o_triggered, 1);
    chk("t4_taddr", bus.o_trig_addr, 9);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    chk("t4_not_done_yet", bus.o_done, 0);
    step(0, 0, 0, 0);
    chk("t4_done", bus.o_done, 1);
    chk("t4_end_addr", bus.o_wr_addr, 1);

    // Mode 11, pre=15: trigger and DONE on the first ARMED cycle.
    start_run(2'b11, 8'd1, 4'd15);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
    chk("t5_armed_busy", bus.o_busy, 1);
    chk("t5_armed_no_trig", bus.o_triggered, 0);
    chk("t5_armed_addr", bus.o_wr_addr, 15);
    step(0, 0, 0, 0);
    chk("t5_done", bus.o_done, 1);
    chk("t5_trig", bus.o_triggered, 1);
    chk("t5_taddr", bus.o_trig_addr, 15);
    chk("t5_addr", bus.o_wr_addr, 0);
    chk("t5_wr_en", bus.o_wr_en, 0);

    // Asynchronous reset in the middle of CAPTURE.
    start_run(2'b00, 8'd1, 4'd0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t1_in_capture", bus.o_busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t1_rst_wr_en", bus.o_wr_en, 0);
    chk("t1_rst_addr", bus.o_wr_addr, 0);
    chk("t1_rst_taddr", bus.o_trig_addr, 0);
    chk("t1_rst_trig", bus.o_triggered, 0);
    chk("t1_rst_done", bus.o_done, 0);
    chk("t1_rst_busy", bus.o_busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk("t1_idle_wr_en", bus.o_wr_en, 0);
    chk("t1_idle_busy", bus.o_busy, 0);
    chk("t1_idle_trig", bus.o_triggered, 0);

    // Stop beats a same-cycle trigger, then stop beats a same-cycle start.
    start_run(2'b00, 8'd1, 4'd0);
    chk("t6_armed", bus.o_busy, 1);
    step(0, 1, 1, 0);
    chk("t6_stop_busy", bus.o_busy, 0);
    chk("t6_stop_wr_en", bus.o_wr_en, 0);
    chk("t6_stop_trig", bus.o_triggered, 0);
    chk("t6_stop_done", bus.o_done, 0);
    bus.i_mode = 2'b11; bus.i_occurrence = 8'd1; bus.i_pre_samples = 4'd0;
    step(1, 1, 0, 0);
    chk("t6_startstop_busy", bus.o_busy, 0);
    step(0, 0, 1, 0);
    chk("t6_after_busy", bus.o_busy, 0);
    chk("t6_after_trig", bus.o_triggered, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
